// File: rtl/fifo_rtl_pkg.sv
// Shared types and defaults for the async FIFO and its read-side adapter.
// Holds the skid-buffer state encoding and the default DSIZE/BURST_LEN.
package fifo_rtl_pkg;

    localparam int FIFO_DSIZE_DEF     = 8;
    localparam int FIFO_BURST_LEN_DEF = 4;

    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// 2-entry skid buffer: registered head output, tail catches a push while the head stalls.
// Ports: clk/rst (sync, active-high), flush, push+din (tail write), pop (head leaves), state, head.
module fifo_skid_buf
    import fifo_rtl_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [DSIZE-1:0] din,
    output skid_state_e      state,
    output logic [DSIZE-1:0] head
);

    skid_state_e      r_state;
    skid_state_e      w_state_nxt;
    logic [DSIZE-1:0] r_d0;
    logic [DSIZE-1:0] r_d1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SK_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = SK_EMPTY;
        end else begin
            case (r_state)
                SK_EMPTY: if (push) w_state_nxt = SK_ONE;
                SK_ONE: begin
                    if (push && !pop)      w_state_nxt = SK_TWO;
                    else if (!push && pop) w_state_nxt = SK_EMPTY;
                end
                SK_TWO:   if (pop) w_state_nxt = SK_ONE;
                default:  w_state_nxt = SK_EMPTY;
            endcase
        end
    end

    // Head is always r_d0; a pop out of TWO promotes the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d0 <= '0;
            r_d1 <= '0;
        end else if (!flush) begin
            case (r_state)
                SK_EMPTY: if (push) r_d0 <= din;
                SK_ONE: begin
                    if (push && pop) r_d0 <= din;
                    else if (push)   r_d1 <= din;
                end
                SK_TWO:   if (pop) r_d0 <= r_d1;
                default: ;
            endcase
        end
    end

    assign state = r_state;
    assign head  = r_d0;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side FIFO consumer: pops into a skid buffer, emits a framed valid/ready stream.
// Ports: rclk/rrst, FIFO rempty/rdata/rinc, en, flush, m_valid/m_ready/m_data/m_last, stat_words/stat_stall.
// Optional counters built only when FIFO_RD_STATS_EN is defined; otherwise stat ports read 0.
module fifo_rd_stream_adapter
    import fifo_rtl_pkg::*;
#(
    parameter int DSIZE     = FIFO_DSIZE_DEF,
    parameter int BURST_LEN = FIFO_BURST_LEN_DEF,
    parameter int STAT_W    = 16
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              rempty,
    input  logic [DSIZE-1:0]  rdata,
    output logic              rinc,
    input  logic              en,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DSIZE-1:0]  m_data,
    output logic              m_last,
    output logic [STAT_W-1:0] stat_words,
    output logic [STAT_W-1:0] stat_stall
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    skid_state_e      w_state;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] r_beat_cnt;

    // Pop decision uses registered state only, so m_ready never reaches rinc.
    assign w_push = ~rrst & en & ~flush & ~rempty & (w_state != SK_TWO);
    assign rinc   = w_push;

    assign m_valid = (w_state != SK_EMPTY);
    assign w_pop   = m_valid & m_ready & ~flush;
    assign m_last  = m_valid & (r_beat_cnt == LAST_CNT);

    fifo_skid_buf #(
        .DSIZE (DSIZE)
    ) u_skid (
        .clk   (rclk),
        .rst   (rrst),
        .flush (flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   (rdata),
        .state (w_state),
        .head  (m_data)
    );

    always_ff @(posedge rclk) begin
        if (rrst || flush) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= (r_beat_cnt == LAST_CNT) ? '0 : r_beat_cnt + 1'b1;
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [STAT_W-1:0] r_stat_words;
    logic [STAT_W-1:0] r_stat_stall;

    // Saturating; flush leaves them alone.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_stat_words <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_pop && (r_stat_words != '1))
                r_stat_words <= r_stat_words + 1'b1;
            if (m_valid && !m_ready && (r_stat_stall != '1))
                r_stat_stall <= r_stat_stall + 1'b1;
        end
    end

    assign stat_words = r_stat_words;
    assign stat_stall = r_stat_stall;
`else
    assign stat_words = '0;
    assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter with a small FIFO model on the read port.
// Stats checks expect saturation at STAT_W=4 when FIFO_RD_STATS_EN is defined, else zeros.
module tb_fifo_rd_stream_adapter;

    localparam int DSIZE     = 8;
    localparam int BURST_LEN = 4;
    localparam int STAT_W    = 4;
`ifdef FIFO_RD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              rclk = 1'b0;
    logic              rrst;
    logic              rempty;
    logic [DSIZE-1:0]  rdata;
    logic              rinc;
    logic              en;
    logic              flush;
    logic              m_valid;
    logic              m_ready;
    logic [DSIZE-1:0]  m_data;
    logic              m_last;
    logic [STAT_W-1:0] stat_words;
    logic [STAT_W-1:0] stat_stall;

    int errors = 0;
    int checks = 0;

    logic [7:0] fmem [0:127];
    int wr_i = 0;
    int rd_i = 0;
    int pops = 0;
    int p0;

    always #5 rclk = ~rclk;

    assign rempty = (rd_i == wr_i);
    assign rdata  = fmem[rd_i[6:0]];

    always @(posedge rclk) begin
        if (rinc) begin
            rd_i <= rd_i + 1;
            pops <= pops + 1;
        end
    end

    fifo_rd_stream_adapter #(
        .DSIZE     (DSIZE),
        .BURST_LEN (BURST_LEN),
        .STAT_W    (STAT_W)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rempty     (rempty),
        .rdata      (rdata),
        .rinc       (rinc),
        .en         (en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .stat_words (stat_words),
        .stat_stall (stat_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] v);
        fmem[wr_i[6:0]] = v;
        wr_i = wr_i + 1;
    endtask

    initial begin
        rrst    = 1'b1;
        en      = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) put(8'(8'h10 + i));

        // reset with FIFO non-empty
        @(negedge rclk);
        @(negedge rclk);
        chk("rst_rinc", 32'(rinc), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_last", 32'(m_last), 0);
        chk("rst_words", 32'(stat_words), 0);
        chk("rst_stall", 32'(stat_stall), 0);
        chk("rst_nopop", 32'(pops), 0);

        // streaming 0x10..0x17
        rrst = 1'b0;
        #1;
        chk("str_rinc", 32'(rinc), 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge rclk);
            chk("str_valid", 32'(m_valid), 1);
            chk("str_data", 32'(m_data), 32'(8'h10 + k));
            chk("str_last", 32'(m_last), 32'((k == 3) || (k == 7)));
        end
        @(negedge rclk);
        chk("str_end", 32'(m_valid), 0);

        // backpressure with 5 queued
        m_ready = 1'b0;
        p0 = pops;
        for (int i = 0; i < 5; i++) put(8'(8'h20 + i));
        repeat (4) @(negedge rclk);
        chk("bp_pops", 32'(pops - p0), 2);
        chk("bp_rinc", 32'(rinc), 0);
        chk("bp_valid", 32'(m_valid), 1);
        chk("bp_hold", 32'(m_data), 32'h20);
        m_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            @(negedge rclk);
            chk("bp_data", 32'(m_data), 32'(8'h20 + i));
            chk("bp_last", 32'(m_last), 32'(i == 3));
        end
        @(negedge rclk);
        chk("bp_end", 32'(m_valid), 0);
        chk("bp_total", 32'(pops - p0), 5);

        // one more beat brings beat_cnt to 2, then flush two buffered
        put(8'h25);
        @(negedge rclk);
        chk("fl_pre", 32'(m_data), 32'h25);
        @(negedge rclk);
        m_ready = 1'b0;
        put(8'h30);
        put(8'h31);
        put(8'h32);
        repeat (3) @(negedge rclk);
        chk("fl_head", 32'(m_data), 32'h30);
        flush   = 1'b1;
        m_ready = 1'b1;
        p0 = pops;
        #1;
        chk("fl_rinc", 32'(rinc), 0);
        @(negedge rclk);
        chk("fl_valid", 32'(m_valid), 0);
        chk("fl_nopop", 32'(pops - p0), 0);
        flush = 1'b0;
        put(8'h33);
        put(8'h34);
        put(8'h35);
        for (int i = 0; i < 4; i++) begin
            @(negedge rclk);
            chk("fl_data", 32'(m_data), 32'(8'h32 + i));
            chk("fl_last", 32'(m_last), 32'(i == 3));
        end
        @(negedge rclk);
        chk("fl_end", 32'(m_valid), 0);

        // drain with en=0
        m_ready = 1'b0;
        put(8'h40);
        put(8'h41);
        put(8'h42);
        repeat (3) @(negedge rclk);
        en      = 1'b0;
        m_ready = 1'b1;
        #1;
        chk("dr_rinc0", 32'(rinc), 0);
        @(negedge rclk);
        chk("dr_data", 32'(m_data), 32'h41);
        chk("dr_valid", 32'(m_valid), 1);
        @(negedge rclk);
        chk("dr_empty", 32'(m_valid), 0);
        chk("dr_rinc1", 32'(rinc), 0);
        chk("dr_fifo", 32'(rempty), 0);
        en = 1'b1;
        @(negedge rclk);
        chk("dr_next", 32'(m_data), 32'h42);
        chk("dr_last", 32'(m_last), 0);
        @(negedge rclk);

        // stats: 3 stalls then 20 beats
        rrst = 1'b1;
        @(negedge rclk);
        rrst    = 1'b0;
        m_ready = 1'b0;
        chk("st_clr", 32'(stat_words), 0);
        put(8'h50);
        @(negedge rclk);
        repeat (3) @(negedge rclk);
        chk("st_stall", 32'(stat_stall), STATS ? 3 : 0);
        m_ready = 1'b1;
        for (int i = 0; i < 19; i++) put(8'(8'h51 + i));
        repeat (24) @(negedge rclk);
        chk("st_idle", 32'(m_valid), 0);
        chk("st_words", 32'(stat_words), STATS ? 15 : 0);
        chk("st_stall2", 32'(stat_stall), STATS ? 3 : 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
